// File: rtl/csr_machine_unit.sv
// Machine-mode CSR file: decode, write/set/clear ops, 64-bit-capable counters, trap/mret stacking.
// Latency: reads, csrIllegal, trapVector and interrupt outputs are combinational; updates commit on the next edge.
// Backpressure: none; every op, trap and mret presented in a cycle is accepted in that cycle.
module csr_machine_unit #(
  parameter int          COUNTER_WIDTH = 64,
  parameter int          RETIRE_WIDTH  = 2,
  parameter bit          VECTORED_EN   = 1'b1,
  parameter logic [31:0] MISA_VALUE    = 32'h40000100,
  parameter logic [31:0] HART_ID       = 32'd0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [11:0]             csrAddress,
  input  logic [1:0]              csrOp,
  input  logic [31:0]             csrWriteData,
  output logic [31:0]             csrReadData,
  output logic                    csrIllegal,
  input  logic [RETIRE_WIDTH-1:0] retireCount,
  input  logic                    trapEnable,
  input  logic                    trapInterrupt,
  input  logic [3:0]              trapCode,
  input  logic [31:0]             trapPC,
  input  logic [31:0]             trapValue,
  input  logic                    mretEnable,
  input  logic                    externalInterrupt,
  input  logic                    timerInterrupt,
  input  logic                    softwareInterrupt,
  output logic [31:0]             trapVector,
  output logic [31:0]             mepcOut,
  output logic                    interruptRequest,
  output logic [3:0]              interruptCode
);

  localparam int UW = COUNTER_WIDTH - 32;

  logic                     status_mie_q, status_mie_d;
  logic                     status_mpie_q, status_mpie_d;
  logic [31:0]              mie_q, mie_d;
  logic [31:0]              mtvec_q, mtvec_d;
  logic [31:0]              mscratch_q, mscratch_d;
  logic [31:0]              mepc_q, mepc_d;
  logic [31:0]              mcause_q, mcause_d;
  logic [31:0]              mtval_q, mtval_d;
  logic [COUNTER_WIDTH-1:0] cycle_q, cycle_d;
  logic [COUNTER_WIDTH-1:0] instret_q, instret_d;

  logic [31:0] mstatus_rd;
  logic [31:0] mip;
  logic [31:0] pending;
  logic [63:0] cycle_ext;
  logic [63:0] instret_ext;
  logic        implemented;
  logic        read_only;
  logic        wr_en;
  logic [31:0] op_result;
  logic [COUNTER_WIDTH-1:0] cycle_inc;
  logic [COUNTER_WIDTH-1:0] instret_inc;

  // MPP is hardwired to machine mode; only MIE and MPIE are state.
  assign mstatus_rd  = {19'd0, 2'b11, 3'd0, status_mpie_q, 3'd0, status_mie_q, 3'd0};
  assign mip         = {20'd0, externalInterrupt, 3'd0, timerInterrupt, 3'd0, softwareInterrupt, 3'd0};
  assign pending     = mip & mie_q;
  assign cycle_ext   = 64'(cycle_q);
  assign instret_ext = 64'(instret_q);
  assign cycle_inc   = cycle_q + COUNTER_WIDTH'(1);
  assign instret_inc = instret_q + COUNTER_WIDTH'(retireCount);
  assign mepcOut     = mepc_q;

  // Address decode and read mux; reads always return the pre-update value.
  always_comb begin
    csrReadData = 32'd0;
    implemented = 1'b1;
    read_only   = 1'b0;
    case (csrAddress)
      12'h300: csrReadData = mstatus_rd;
      12'h301: begin csrReadData = MISA_VALUE; read_only = 1'b1; end
      12'h304: csrReadData = mie_q;
      12'h305: csrReadData = mtvec_q;
      12'h340: csrReadData = mscratch_q;
      12'h341: csrReadData = mepc_q;
      12'h342: csrReadData = mcause_q;
      12'h343: csrReadData = mtval_q;
      12'h344: csrReadData = mip;
      12'hB00: csrReadData = cycle_ext[31:0];
      12'hB02: csrReadData = instret_ext[31:0];
      12'hB80: csrReadData = cycle_ext[63:32];
      12'hB82: csrReadData = instret_ext[63:32];
      12'hF11, 12'hF12, 12'hF13: read_only = 1'b1;
      12'hF14: begin csrReadData = HART_ID; read_only = 1'b1; end
      default: implemented = 1'b0;
    endcase
  end

  assign csrIllegal = !implemented || ((csrOp != 2'b00) && read_only);
  assign wr_en      = (csrOp != 2'b00) && !csrIllegal;

  // Write/set/clear operand applied to the current CSR value.
  always_comb begin
    case (csrOp)
      2'b01:   op_result = csrWriteData;
      2'b10:   op_result = csrReadData | csrWriteData;
      2'b11:   op_result = csrReadData & ~csrWriteData;
      default: op_result = csrReadData;
    endcase
  end

  // Counter next state: a written half replaces the increment and blocks carry out of a written low half.
  always_comb begin
    cycle_d   = cycle_inc;
    instret_d = instret_inc;
    if (wr_en && csrAddress == 12'hB00) cycle_d   = {cycle_q[COUNTER_WIDTH-1:32], op_result};
    if (wr_en && csrAddress == 12'hB80) cycle_d   = {op_result[UW-1:0], cycle_inc[31:0]};
    if (wr_en && csrAddress == 12'hB02) instret_d = {instret_q[COUNTER_WIDTH-1:32], op_result};
    if (wr_en && csrAddress == 12'hB82) instret_d = {op_result[UW-1:0], instret_inc[31:0]};
  end

  // CSR next state: op first, then mret, then trap, so later sources win on shared fields.
  always_comb begin
    status_mie_d  = status_mie_q;
    status_mpie_d = status_mpie_q;
    mie_d         = mie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    if (wr_en) begin
      case (csrAddress)
        12'h300: begin status_mie_d = op_result[3]; status_mpie_d = op_result[7]; end
        12'h304: mie_d      = op_result & 32'h0000_0888;
        12'h305: mtvec_d    = {op_result[31:2], 1'b0, VECTORED_EN ? op_result[0] : 1'b0};
        12'h340: mscratch_d = op_result;
        12'h341: mepc_d     = {op_result[31:2], 2'b00};
        12'h342: mcause_d   = op_result;
        12'h343: mtval_d    = op_result;
        default: ;
      endcase
    end
    if (mretEnable) begin
      status_mie_d  = status_mpie_q;
      status_mpie_d = 1'b1;
    end
    if (trapEnable) begin
      mepc_d        = {trapPC[31:2], 2'b00};
      mcause_d      = {trapInterrupt, 27'd0, trapCode};
      mtval_d       = trapValue;
      status_mpie_d = status_mie_q;
      status_mie_d  = 1'b0;
    end
  end

  // State registers; reset leaves every CSR zero (MPP is constant, so mstatus reads 0x1800).
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      status_mie_q  <= 1'b0;
      status_mpie_q <= 1'b0;
      mie_q         <= 32'd0;
      mtvec_q       <= 32'd0;
      mscratch_q    <= 32'd0;
      mepc_q        <= 32'd0;
      mcause_q      <= 32'd0;
      mtval_q       <= 32'd0;
      cycle_q       <= '0;
      instret_q     <= '0;
    end else begin
      status_mie_q  <= status_mie_d;
      status_mpie_q <= status_mpie_d;
      mie_q         <= mie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      cycle_q       <= cycle_d;
      instret_q     <= instret_d;
    end
  end

  // Trap target from registered mtvec; only interrupts use the vectored offset.
  always_comb begin
    trapVector = {mtvec_q[31:2], 2'b00};
    if (mtvec_q[0] && trapInterrupt) trapVector = {mtvec_q[31:2], 2'b00} + {26'd0, trapCode, 2'b00};
  end

  // Interrupt request and fixed-priority code: external, then software, then timer.
  always_comb begin
    interruptRequest = status_mie_q && (pending != 32'd0);
    interruptCode    = 4'd0;
    if (pending[11])     interruptCode = 4'd11;
    else if (pending[3]) interruptCode = 4'd3;
    else if (pending[7]) interruptCode = 4'd7;
  end

endmodule

// File: tb/tb_csr_machine_unit.sv
// Directed and randomized checks of csr_machine_unit against a CSR-level reference model.
// Outputs are compared each cycle at the falling edge; the model advances with each rising edge.
// Counters are modelled as plain 64-bit numbers, CSRs as whole 32-bit values.
module tb_csr_machine_unit;

  logic        clock;
  logic        reset;
  logic [11:0] csrAddress;
  logic [1:0]  csrOp;
  logic [31:0] csrWriteData;
  logic [31:0] csrReadData;
  logic        csrIllegal;
  logic [1:0]  retireCount;
  logic        trapEnable;
  logic        trapInterrupt;
  logic [3:0]  trapCode;
  logic [31:0] trapPC;
  logic [31:0] trapValue;
  logic        mretEnable;
  logic        externalInterrupt;
  logic        timerInterrupt;
  logic        softwareInterrupt;
  logic [31:0] trapVector;
  logic [31:0] mepcOut;
  logic        interruptRequest;
  logic [3:0]  interruptCode;

  int n_pass  = 0;
  int n_total = 0;

  // reference model state
  bit          m_mie, m_mpie;
  logic [31:0] m_mie_reg, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [63:0] m_cycle, m_instret;

  logic [11:0] addr_list [21] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342,
                                  12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hF11,
                                  12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h000, 12'h3A0, 12'hB01};

  csr_machine_unit dut (
    .clock(clock), .reset(reset),
    .csrAddress(csrAddress), .csrOp(csrOp), .csrWriteData(csrWriteData),
    .csrReadData(csrReadData), .csrIllegal(csrIllegal),
    .retireCount(retireCount),
    .trapEnable(trapEnable), .trapInterrupt(trapInterrupt), .trapCode(trapCode),
    .trapPC(trapPC), .trapValue(trapValue), .mretEnable(mretEnable),
    .externalInterrupt(externalInterrupt), .timerInterrupt(timerInterrupt),
    .softwareInterrupt(softwareInterrupt),
    .trapVector(trapVector), .mepcOut(mepcOut),
    .interruptRequest(interruptRequest), .interruptCode(interruptCode)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_mip();
    logic [31:0] v;
    v = 32'd0;
    v[11] = externalInterrupt;
    v[7]  = timerInterrupt;
    v[3]  = softwareInterrupt;
    return v;
  endfunction

  function automatic void model_read(input logic [11:0] a, output logic [31:0] v,
                                     output bit legal, output bit ro);
    v = 32'd0; legal = 1'b1; ro = 1'b0;
    case (a)
      12'h300: v = 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: begin v = 32'h40000100; ro = 1'b1; end
      12'h304: v = m_mie_reg;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = model_mip();
      12'hB00: v = m_cycle[31:0];
      12'hB02: v = m_instret[31:0];
      12'hB80: v = m_cycle[63:32];
      12'hB82: v = m_instret[63:32];
      12'hF11, 12'hF12, 12'hF13, 12'hF14: ro = 1'b1;
      default: legal = 1'b0;
    endcase
  endfunction

  task automatic model_reset();
    m_mie = 0; m_mpie = 0;
    m_mie_reg = 0; m_mtvec = 0; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_cycle = 0; m_instret = 0;
  endtask

  // advance the model by one rising edge using the inputs currently applied
  task automatic model_step();
    logic [31:0] old, nv;
    bit legal, ro, wr, old_mie, old_mpie;
    logic [63:0] c, r;
    model_read(csrAddress, old, legal, ro);
    wr = (csrOp != 2'b00) && legal && !ro;
    case (csrOp)
      2'b01:   nv = csrWriteData;
      2'b10:   nv = old | csrWriteData;
      default: nv = old & ~csrWriteData;
    endcase
    c = m_cycle + 64'd1;
    r = m_instret + 64'(retireCount);
    if (wr && csrAddress == 12'hB00) c = {m_cycle[63:32], nv};
    if (wr && csrAddress == 12'hB80) c = {nv, c[31:0]};
    if (wr && csrAddress == 12'hB02) r = {m_instret[63:32], nv};
    if (wr && csrAddress == 12'hB82) r = {nv, r[31:0]};
    m_cycle = c; m_instret = r;
    old_mie = m_mie; old_mpie = m_mpie;
    if (wr) begin
      case (csrAddress)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h304: m_mie_reg = nv & 32'h888;
        12'h305: m_mtvec = nv & ~32'h2;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv & ~32'h3;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        default: ;
      endcase
    end
    if (trapEnable) begin
      m_mepc = trapPC & ~32'h3;
      m_mcause = (32'(trapInterrupt) << 31) | 32'(trapCode);
      m_mtval = trapValue;
      m_mpie = old_mie;
      m_mie = 0;
    end else if (mretEnable) begin
      m_mie = old_mpie;
      m_mpie = 1;
    end
  endtask

  task automatic check_outputs();
    logic [31:0] v, pend, tv;
    bit legal, ro;
    logic [3:0] code;
    model_read(csrAddress, v, legal, ro);
    chk("readData", csrReadData, v);
    chk("illegal", 32'(csrIllegal), 32'(!legal || (csrOp != 2'b00 && ro)));
    tv = m_mtvec & ~32'h3;
    if (m_mtvec[0] && trapInterrupt) tv = tv + 4 * 32'(trapCode);
    chk("trapVector", trapVector, tv);
    chk("mepcOut", mepcOut, m_mepc);
    pend = model_mip() & m_mie_reg;
    code = pend[11] ? 4'd11 : pend[3] ? 4'd3 : pend[7] ? 4'd7 : 4'd0;
    chk("irqReq", 32'(interruptRequest), 32'(m_mie && pend != 0));
    chk("irqCode", 32'(interruptCode), 32'(code));
  endtask

  task automatic cycle();
    @(negedge clock);
    check_outputs();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic rd_lit(input logic [11:0] a, input logic [31:0] exp, input string tag);
    csrAddress = a; csrOp = 2'b00;
    #1;
    chk(tag, csrReadData, exp);
  endtask

  initial begin
    logic [31:0] exp;
    reset = 0; csrAddress = 0; csrOp = 0; csrWriteData = 0; retireCount = 0;
    trapEnable = 0; trapInterrupt = 0; trapCode = 0; trapPC = 0; trapValue = 0;
    mretEnable = 0; externalInterrupt = 0; timerInterrupt = 0; softwareInterrupt = 0;
    model_reset();
    repeat (3) @(posedge clock);
    #1 reset = 1;

    // count for a while, then assert reset mid-count
    retireCount = 2'd1;
    repeat (5) cycle();
    #1 reset = 0;
    model_reset();
    for (int i = 0; i < 17; i++) begin
      exp = (addr_list[i] == 12'h300) ? 32'h00001800 :
            (addr_list[i] == 12'h301) ? 32'h40000100 : 32'h0;
      rd_lit(addr_list[i], exp, $sformatf("reset_rd_%h", addr_list[i]));
      chk("reset_illegal", 32'(csrIllegal), 32'h0);
    end
    chk("reset_irq", 32'(interruptRequest), 32'h0);
    chk("reset_tvec", trapVector, 32'h0);
    chk("reset_mepc", mepcOut, 32'h0);
    retireCount = 2'd0;
    @(posedge clock);
    #1 reset = 1;

    // mcycle carry from low half into high half
    csrAddress = 12'hB80; csrOp = 2'b01; csrWriteData = 32'h0; cycle();
    csrAddress = 12'hB00; csrWriteData = 32'hFFFFFFFF; cycle();
    csrOp = 2'b00; cycle(); cycle();
    rd_lit(12'hB00, 32'h1, "mcycle_lo_after_carry");
    rd_lit(12'hB80, 32'h1, "mcycle_hi_after_carry");

    // multi-retire counting and write overriding the increment
    retireCount = 2'd3;
    repeat (4) cycle();
    retireCount = 2'd0;
    rd_lit(12'hB02, 32'd12, "minstret_12");
    csrAddress = 12'hB02; csrOp = 2'b01; csrWriteData = 32'd5; retireCount = 2'd3; cycle();
    retireCount = 2'd0;
    rd_lit(12'hB02, 32'd5, "minstret_write_wins");

    // interrupt request, vectored trap target, trap entry and mret
    csrAddress = 12'h300; csrOp = 2'b01; csrWriteData = 32'h8; cycle();
    csrAddress = 12'h304; csrWriteData = 32'h800; cycle();
    csrOp = 2'b00; externalInterrupt = 1;
    #1;
    chk("irq_ext_req", 32'(interruptRequest), 32'h1);
    chk("irq_ext_code", 32'(interruptCode), 32'd11);
    csrAddress = 12'h305; csrOp = 2'b01; csrWriteData = 32'h00000101; cycle();
    csrOp = 2'b00; trapInterrupt = 1; trapCode = 4'd11;
    #1;
    chk("tvec_vectored", trapVector, 32'h0000012C);
    trapEnable = 1; trapPC = 32'h00002000; trapValue = 32'h0; cycle();
    trapEnable = 0; trapInterrupt = 0; trapCode = 0;
    rd_lit(12'h342, 32'h8000000B, "mcause_after_trap");
    rd_lit(12'h300, 32'h00001880, "mstatus_after_trap");
    mretEnable = 1; cycle();
    mretEnable = 0;
    rd_lit(12'h300, 32'h00001888, "mstatus_after_mret");

    // trap beats a same-cycle op on mepc
    csrAddress = 12'h341; csrOp = 2'b01; csrWriteData = 32'h1234;
    trapEnable = 1; trapPC = 32'hABCD0007; cycle();
    trapEnable = 0; csrOp = 2'b00;
    chk("mepc_trap_wins", mepcOut, 32'hABCD0004);

    // set on read-only misa, then an unimplemented address
    csrAddress = 12'h301; csrOp = 2'b10; csrWriteData = 32'hFFFFFFFF;
    #1;
    chk("misa_set_illegal", 32'(csrIllegal), 32'h1);
    cycle();
    rd_lit(12'h301, 32'h40000100, "misa_unchanged");
    rd_lit(12'h7C0, 32'h0, "rd_7c0_data");
    chk("rd_7c0_illegal", 32'(csrIllegal), 32'h1);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      csrAddress        = addr_list[$urandom_range(0, 20)];
      csrOp             = 2'($urandom_range(0, 3));
      csrWriteData      = $urandom;
      retireCount       = 2'($urandom_range(0, 3));
      trapEnable        = ($urandom_range(0, 7) == 0);
      trapInterrupt     = 1'($urandom_range(0, 1));
      trapCode          = 4'($urandom_range(0, 15));
      trapPC            = $urandom;
      trapValue         = $urandom;
      mretEnable        = ($urandom_range(0, 7) == 0);
      externalInterrupt = 1'($urandom_range(0, 1));
      timerInterrupt    = 1'($urandom_range(0, 1));
      softwareInterrupt = 1'($urandom_range(0, 1));
      cycle();
    end

    // reset arriving while a trap is presented discards the trap
    csrOp = 2'b00; mretEnable = 0; trapEnable = 1; trapPC = 32'h55550004;
    #1 reset = 0;
    model_reset();
    rd_lit(12'h341, 32'h0, "reset_mid_trap_mepc");
    rd_lit(12'h300, 32'h00001800, "reset_mid_trap_mstatus");
    @(posedge clock);
    #1;
    chk("reset_mid_trap_mepcOut", mepcOut, 32'h0);
    trapEnable = 0; reset = 1;
    csrAddress = 12'hB00;
    repeat (3) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
